vga_write_queue: RTL and testbench

// Pixel-write buffer between the MiniAlu VGA instruction and the VGA video memory write port.
// - Accepts (row, col, color) writes from the CPU at up to one per clock and queues them in a FIFO.
// - Drains to video memory only while the VGA controller reports blanking, so the CPU never writes
//   a pixel during active scan.
// - Exposes full/empty/count so firmware can poll before issuing VGA writes.
//

---
 rtl/vga_write_queue_if.sv | 36 +++
 rtl/vga_write_queue.sv | 126 ++++++++++++
 tb/tb_vga_write_queue.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_write_queue_if.sv
// Handshake/status bundle between the MiniAlu VGA write path and the pixel write queue.
interface vga_write_queue_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned COLOR_W = 3
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               iWrite;
    logic [7:0]         iRow;
    logic [7:0]         iCol;
    logic [COLOR_W-1:0] iColor;
    logic               iFlush;
    logic               iBlank;
    logic               oFull;
    logic               oEmpty;
    logic [CNT_W-1:0]   oCount;
    logic               oOverflow;
    logic               oMemWriteEnable;
    logic [ADDR_W-1:0]  oMemWriteAddress;
    logic [COLOR_W-1:0] oMemData;

    // CPU / controller side: drives requests and blanking, observes status and memory writes.
    modport master (
        output iWrite, iRow, iCol, iColor, iFlush, iBlank,
        input  oFull, oEmpty, oCount, oOverflow,
        input  oMemWriteEnable, oMemWriteAddress, oMemData
    );

    // Queue side.
    modport slave (
        input  iWrite, iRow, iCol, iColor, iFlush, iBlank,
        output oFull, oEmpty, oCount, oOverflow,
        output oMemWriteEnable, oMemWriteAddress, oMemData
    );
endinterface

// File: rtl/vga_write_queue.sv
// Pixel write FIFO that only drains into video memory while the VGA controller is blanking.
module vga_write_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned COLOR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    vga_write_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } entry_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               full_q;
    logic               empty_q;
    logic               ovf_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [COLOR_W-1:0] data_q;
    state_t             state_q;

    logic               push_c;
    logic               pop_c;
    entry_t             wr_entry_c;
    entry_t             rd_entry_c;

    // Push/pop qualification and next occupancy; full-ness uses the pre-edge count and flush wins.
    always_comb begin
        push_c     = 1'b0;
        pop_c      = 1'b0;
        count_d    = count_q;
        wr_entry_c = '{addr: ADDR_W'({bus.iRow, bus.iCol}), color: bus.iColor};
        rd_entry_c = mem_q[rd_ptr_q];
        if (bus.iFlush) begin
            count_d = '0;
        end else begin
            push_c  = bus.iWrite && !full_q;
            pop_c   = bus.iBlank && !empty_q;
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Entry storage; contents need no reset because pointers and count gate every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_entry_c;
        end
    end

    // Pointers, status flags, drain FSM and the registered memory write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            state_q  <= IDLE;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);

            if (bus.iWrite && full_q && !bus.iFlush) begin
                ovf_q <= 1'b1;
            end

            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end

            if (bus.iFlush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            we_q <= pop_c;
            if (pop_c) begin
                addr_q <= rd_entry_c.addr;
                data_q <= rd_entry_c.color;
            end

            case (state_q)
                IDLE: begin
                    if (pop_c && count_d != '0) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pop_c || count_d == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oCount           = count_q;
    assign bus.oFull            = full_q;
    assign bus.oEmpty           = empty_q;
    assign bus.oOverflow        = ovf_q;
    assign bus.oMemWriteEnable  = we_q;
    assign bus.oMemWriteAddress = addr_q;
    assign bus.oMemData         = data_q;
endmodule

// File: tb/tb_vga_write_queue.sv
// Self-checking bench for vga_write_queue against a queue-based reference model.
module tb_vga_write_queue;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned VW      = CNT_W + 4 + ADDR_W + COLOR_W;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    vga_write_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();
    vga_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents as queues plus the last memory write seen.
    logic [ADDR_W-1:0]  qa [$];
    logic [COLOR_W-1:0] qc [$];
    logic               m_ovf;
    logic               m_we;
    logic [ADDR_W-1:0]  m_addr;
    logic [COLOR_W-1:0] m_data;

    task automatic model_reset();
        qa.delete();
        qc.delete();
        m_ovf  = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        int sz;
        sz = qa.size();
        return {CNT_W'(sz), (sz == int'(DEPTH)), (sz == 0), m_ovf, m_we, m_addr, m_data};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.oCount, bus.oFull, bus.oEmpty, bus.oOverflow,
                bus.oMemWriteEnable, bus.oMemWriteAddress, bus.oMemData};
    endfunction

    // Drive one clock of inputs, advance the model across the edge, land 1 time unit after it.
    task automatic step(input logic w, input logic [7:0] r, input logic [7:0] c,
                        input logic [COLOR_W-1:0] col, input logic fl, input logic bl);
        int sz;
        bus.iWrite = w;
        bus.iRow   = r;
        bus.iCol   = c;
        bus.iColor = col;
        bus.iFlush = fl;
        bus.iBlank = bl;
        @(posedge clk);
        sz = qa.size();
        if (fl) begin
            qa.delete();
            qc.delete();
            m_we = 1'b0;
        end else begin
            if (bl && sz > 0) begin
                m_we   = 1'b1;
                m_addr = qa.pop_front();
                m_data = qc.pop_front();
            end else begin
                m_we = 1'b0;
            end
            if (w) begin
                if (sz == int'(DEPTH)) begin
                    m_ovf = 1'b1;
                end else begin
                    qa.push_back(ADDR_W'(r) * 256 + ADDR_W'(c));
                    qc.push_back(col);
                end
            end
        end
        #1;
    endtask

    task automatic rnd_push(input logic bl);
        step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             COLOR_W'($urandom_range(0, 7)), 1'b0, bl);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iWrite = 1'b0; bus.iRow = '0; bus.iCol = '0; bus.iColor = '0;
        bus.iFlush = 1'b0; bus.iBlank = 1'b0;
        model_reset();
        #25;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
        end
        n_checks++;
        if (obs_vec() !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_const: got %h", obs_vec());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        step(1'b1, 8'd3, 8'd5, 3'b101, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_wait[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
        n_checks++;
        if ({bus.oMemWriteEnable, bus.oMemWriteAddress, bus.oMemData, bus.oEmpty} !== {1'b1, 16'h0305, 3'b101, 1'b1}) begin
            n_fail++;
            $display("FAIL single_strobe: got we=%b addr=%h data=%b empty=%b want 1/0305/101/1",
                     bus.oMemWriteEnable, bus.oMemWriteAddress, bus.oMemData, bus.oEmpty);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_after[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            rnd_push(1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_fill[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({bus.oFull, bus.oOverflow, bus.oCount} !== {1'b1, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL ovf_flags: got full=%b ovf=%b count=%0d want 1/1/8",
                     bus.oFull, bus.oOverflow, bus.oCount);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_blank_pause();
        logic [4:0] pat [12];
        for (int i = 0; i < 6; i++) rnd_push(1'b0);
        for (int i = 0; i < 12; i++) begin
            logic bl;
            bl = (i < 3) || (i >= 7);
            step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, bl);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) rnd_push(1'b0);
        rnd_push(1'b1);
        n_checks++;
        if ({bus.oCount, bus.oOverflow, bus.oMemWriteEnable} !== {4'd7, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL full_pop_edge: got count=%0d ovf=%b we=%b want 7/1/1",
                     bus.oCount, bus.oOverflow, bus.oMemWriteEnable);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            rnd_push(1'b1);
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.oCount !== 4'd4) begin
                n_fail++;
                $display("FAIL push_pop[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) rnd_push(1'b0);
        step(1'b1, 8'd9, 8'd9, 3'b111, 1'b1, 1'b0);
        n_checks++;
        if ({bus.oCount, bus.oEmpty} !== {4'd0, 1'b1} || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL flush: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
            n_checks++;
            if (bus.oMemWriteEnable !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL flush_blank[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) rnd_push(1'b0);
        step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({bus.oMemWriteEnable, bus.oCount, bus.oEmpty} !== {1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got we=%b count=%0d empty=%b want 0/0/1",
                     bus.oMemWriteEnable, bus.oCount, bus.oEmpty);
        end
        @(negedge clk);
        rst = 1'b0;
        rnd_push(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 COLOR_W'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_blank_pause();
        test_full_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
